// File: rtl/dram_pkg.sv
// Shared DRAM request-port definitions. The responder and the core-side glue both use them.
package dram_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    localparam int unsigned DRAM_ADDR_W = 27;
    localparam int unsigned DRAM_DATA_W = 32;

    // LATENCY is limited to 1..255, so an 8-bit countdown is enough
    localparam int unsigned LAT_CNT_W = 8;

endpackage

// File: rtl/dram_resp_mem.sv
// Single-port word RAM with a write enable and a registered read, written so it infers as BRAM.
module dram_resp_mem #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata;

    // Read data changes only on a read strobe, so it stays stable until the next read
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dram_responder.sv
// Memory-side responder for the core DRAM port: one outstanding request, programmable latency,
// a stall input, sticky protocol-error flags and completion counters.
module dram_responder
    import dram_pkg::*;
#(
    parameter int unsigned ADDR_W  = 14,
    parameter int unsigned LATENCY = 4,
    parameter int unsigned CNT_W   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_dram,
    input  logic                   rw_dram,
    input  logic [DRAM_ADDR_W-1:0] addr_dram,
    input  logic [DRAM_DATA_W-1:0] din_dram,
    input  logic                   stall,
    output logic                   ready_dram,
    output logic [DRAM_DATA_W-1:0] dout_dram,
    output logic                   busy,
    output logic                   overrun,
    output logic                   oor,
    output logic [CNT_W-1:0]       rd_count,
    output logic [CNT_W-1:0]       wr_count
);

    state_e                 r_state;
    logic                   r_rw;
    logic [LAT_CNT_W-1:0]   r_cnt;
    logic                   r_cap_pend;
    logic [DRAM_DATA_W-1:0] r_cap;
    logic                   r_ready;
    logic [DRAM_DATA_W-1:0] r_dout;
    logic                   r_busy;
    logic                   r_overrun;
    logic                   r_oor;
    logic [CNT_W-1:0]       r_rd_cnt;
    logic [CNT_W-1:0]       r_wr_cnt;

    logic                   w_accept;
    logic                   w_addr_bad;
    logic [ADDR_W-1:0]      w_idx;
    logic [DRAM_DATA_W-1:0] w_rdata;

    assign w_accept   = valid_dram && (r_state == S_IDLE) && !rst;
    assign w_idx      = addr_dram[ADDR_W+1:2];
    assign w_addr_bad = ((addr_dram >> (ADDR_W + 2)) != '0) || (addr_dram[1:0] != 2'b00);

    dram_resp_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DRAM_DATA_W)
    ) u_mem (
        .i_clk   (clk),
        .i_we    (w_accept && (rw_dram == RW_WRITE)),
        .i_re    (w_accept && (rw_dram == RW_READ)),
        .i_addr  (w_idx),
        .i_wdata (din_dram),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_rw       <= RW_READ;
            r_cnt      <= '0;
            r_cap_pend <= 1'b0;
            r_ready    <= 1'b0;
            r_dout     <= '0;
            r_busy     <= 1'b0;
            r_overrun  <= 1'b0;
            r_oor      <= 1'b0;
            r_rd_cnt   <= '0;
            r_wr_cnt   <= '0;
        end else begin
            r_cap_pend <= 1'b0;
            if (r_cap_pend) begin
                r_cap <= w_rdata;
            end
            if (valid_dram && w_addr_bad) begin
                r_oor <= 1'b1;
            end
            if (valid_dram && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (valid_dram) begin
                        r_rw       <= rw_dram;
                        r_cnt      <= LAT_CNT_W'(LATENCY - 1);
                        r_cap_pend <= (rw_dram == RW_READ);
                        r_busy     <= 1'b1;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!stall) begin
                        if (r_cnt == '0) begin
                            r_ready <= 1'b1;
                            r_state <= S_RESP;
                            // With LATENCY=1 the capture register is loaded on this same edge
                            if (r_rw == RW_READ) begin
                                r_dout <= r_cap_pend ? w_rdata : r_cap;
                            end
                        end else begin
                            r_cnt <= r_cnt - LAT_CNT_W'(1);
                        end
                    end
                end
                S_RESP: begin
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                    if (r_rw == RW_READ) begin
                        r_rd_cnt <= r_rd_cnt + CNT_W'(1);
                    end else begin
                        r_wr_cnt <= r_wr_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ready_dram = r_ready;
    assign dout_dram  = r_dout;
    assign busy       = r_busy;
    assign overrun    = r_overrun;
    assign oor        = r_oor;
    assign rd_count   = r_rd_cnt;
    assign wr_count   = r_wr_cnt;

endmodule
